xbus_arbiter: RTL and testbench

- Shares one blocking XBus channel between NUM_WR writer MCX cores and a single reader core.
- Writers post a value and stall until acknowledged. The reader stalls until a value is delivered.
- Writer selection is round-robin. Delivered values are saturated to the numeric range of the MCX accumulator (-999..999).
- The block sits between the MCX cores' XBus pins and their stall logic. It does not decode instructions.

---
 rtl/xbus_arbiter.sv | 139 +++++++++++++
 tb/tb_xbus_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/xbus_arbiter.sv
// Round-robin arbiter sharing one blocking XBus channel between NUM_WR writers and one reader.
// Optional per-writer wait timeout enabled by defining XBUS_TIMEOUT_EN.
module xbus_arbiter #(
  parameter int unsigned NUM_WR      = 4,
  parameter int unsigned DATA_W      = 11,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_WR-1:0]           wr_req,
  input  logic [NUM_WR*DATA_W-1:0]    wr_data,
  output logic [NUM_WR-1:0]           wr_ack,
  output logic [NUM_WR-1:0]           wr_err,
  input  logic                        rd_req,
  output logic signed [DATA_W-1:0]    rd_data,
  output logic                        rd_valid,
  output logic [$clog2(NUM_WR)-1:0]   grant_id,
  output logic                        busy
);

  localparam int unsigned GW = $clog2(NUM_WR);
  localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'(999);
  localparam logic signed [DATA_W-1:0] SAT_MIN = DATA_W'(-999);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t                     state_q, state_d;
  logic [GW-1:0]              grant_d;
  logic [GW-1:0]              win;
  logic [GW-1:0]              cand;
  logic                       found;
  logic signed [DATA_W-1:0]   sel;
  logic signed [DATA_W-1:0]   data_d;
  logic [NUM_WR-1:0]          ack_d;
  logic                       valid_d;
  logic                       busy_d;

  // Clamp to the MCX accumulator range.
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX;
    else if (x < SAT_MIN) return SAT_MIN;
    else                  return x;
  endfunction

  // Winner search, data mux and next-state/output decode.
  always_comb begin
    state_d = state_q;
    grant_d = grant_id;
    data_d  = rd_data;
    ack_d   = '0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    win     = grant_id;
    cand    = '0;
    found   = 1'b0;
    sel     = '0;

    for (int unsigned k = 1; k <= NUM_WR; k++) begin
      cand = GW'((32'(grant_id) + k) % NUM_WR);
      if (!found && wr_req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    for (int unsigned i = 0; i < NUM_WR; i++) begin
      if (GW'(i) == win) sel = wr_data[i*DATA_W +: DATA_W];
    end

    case (state_q)
      S_IDLE: begin
        if (rd_req && found) begin
          state_d = S_ACK;
          grant_d = win;
          data_d  = sat(sel);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          for (int unsigned i = 0; i < NUM_WR; i++) begin
            ack_d[i] = (GW'(i) == win);
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_id <= GW'(NUM_WR - 1);
      rd_data  <= '0;
      wr_ack   <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_id <= grant_d;
      rd_data  <= data_d;
      wr_ack   <= ack_d;
      rd_valid <= valid_d;
      busy     <= busy_d;
    end
  end

`ifdef XBUS_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] to_cnt [NUM_WR];

  // Per-writer wait counter; the request itself is never masked.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err <= '0;
      for (int unsigned i = 0; i < NUM_WR; i++) to_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_WR; i++) begin
        wr_err[i] <= 1'b0;
        if (!wr_req[i] || ack_d[i]) begin
          to_cnt[i] <= '0;
        end else if ((32'(to_cnt[i]) + 32'd1) == TIMEOUT_CYC) begin
          to_cnt[i] <= '0;
          wr_err[i] <= 1'b1;
        end else begin
          to_cnt[i] <= to_cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  // No wait counters in this build; the error lines are tied low.
  assign wr_err = {NUM_WR{1'b0}} & {NUM_WR{TIMEOUT_CYC != 0}};
`endif

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed bench for xbus_arbiter: vector table plus hand sequences for idle wait and timeout.
module tb_xbus_arbiter;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         wr_req;
  logic [43:0]        wr_data;
  logic [3:0]         wr_ack;
  logic [3:0]         wr_err;
  logic               rd_req;
  logic signed [10:0] rd_data;
  logic               rd_valid;
  logic [1:0]         grant_id;
  logic               busy;

  int n_pass  = 0;
  int n_total = 0;

  xbus_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .wr_req   (wr_req),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .wr_err   (wr_err),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       rd;
    logic [3:0] req;
    int         d0, d1, d2, d3;
    logic [3:0] e_ack;
    logic       e_valid;
    int         e_data;
    int         e_grant;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rd, input logic [3:0] req,
                     input int d0, input int d1, input int d2, input int d3,
                     input logic [3:0] e_ack, input logic e_valid, input int e_data,
                     input int e_grant, input logic e_busy);
    vec_t v;
    v.rst = r; v.rd = rd; v.req = req;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
    v.e_ack = e_ack; v.e_valid = e_valid; v.e_data = e_data;
    v.e_grant = e_grant; v.e_busy = e_busy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic drive(input logic r, input logic rd, input logic [3:0] req,
                       input int d0, input int d1, input int d2, input int d3);
    rst     = r;
    rd_req  = rd;
    wr_req  = req;
    wr_data = {11'(d3), 11'(d2), 11'(d1), 11'(d0)};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;

    // reset and single transfer
    add(1, 0, 4'b0000,   0,  0,  0,  0, 4'b0000, 0,    0, 3, 0);
    add(0, 1, 4'b0001, 123,  0,  0,  0, 4'b0001, 1,  123, 0, 1);
    add(0, 1, 4'b0001, 123,  0,  0,  0, 4'b0000, 0,  123, 0, 0);
    add(0, 0, 4'b0000,   0,  0,  0,  0, 4'b0000, 0,  123, 0, 0);
    // round robin over all four writers
    add(1, 0, 4'b0000,   0,  0,  0,  0, 4'b0000, 0,    0, 3, 0);
    add(0, 1, 4'b1111,  10, 11, 12, 13, 4'b0001, 1,   10, 0, 1);
    add(0, 1, 4'b1111,  10, 11, 12, 13, 4'b0000, 0,   10, 0, 0);
    add(0, 1, 4'b1111,  10, 11, 12, 13, 4'b0010, 1,   11, 1, 1);
    add(0, 1, 4'b1111,  10, 11, 12, 13, 4'b0000, 0,   11, 1, 0);
    add(0, 1, 4'b1111,  10, 11, 12, 13, 4'b0100, 1,   12, 2, 1);
    add(0, 1, 4'b1111,  10, 11, 12, 13, 4'b0000, 0,   12, 2, 0);
    add(0, 1, 4'b1111,  10, 11, 12, 13, 4'b1000, 1,   13, 3, 1);
    add(0, 1, 4'b1111,  10, 11, 12, 13, 4'b0000, 0,   13, 3, 0);
    add(0, 1, 4'b1111,  10, 11, 12, 13, 4'b0001, 1,   10, 0, 1);
    add(0, 1, 4'b1111,  10, 11, 12, 13, 4'b0000, 0,   10, 0, 0);
    // saturation; writer 2 alone keeps winning
    add(0, 1, 4'b0100,   0,  0, 1023, 0, 4'b0100, 1,  999, 2, 1);
    add(0, 1, 4'b0100,   0,  0, 1023, 0, 4'b0000, 0,  999, 2, 0);
    add(0, 1, 4'b0100,   0,  0, -1024, 0, 4'b0100, 1, -999, 2, 1);
    add(0, 1, 4'b0100,   0,  0, -1024, 0, 4'b0000, 0, -999, 2, 0);
    add(0, 1, 4'b0100,   0,  0,    0, 0, 4'b0100, 1,    0, 2, 1);
    add(0, 1, 4'b0100,   0,  0,    0, 0, 4'b0000, 0,    0, 2, 0);
    add(0, 1, 4'b0100,   0,  0, -999, 0, 4'b0100, 1, -999, 2, 1);
    add(0, 1, 4'b0100,   0,  0, -999, 0, 4'b0000, 0, -999, 2, 0);
    add(0, 1, 4'b0100,   0,  0,  999, 0, 4'b0100, 1,  999, 2, 1);
    add(0, 1, 4'b0100,   0,  0,  999, 0, 4'b0000, 0,  999, 2, 0);
    add(0, 1, 4'b0100,   0,  0, -1000, 0, 4'b0100, 1, -999, 2, 1);
    add(0, 1, 4'b0100,   0,  0, -1000, 0, 4'b0000, 0, -999, 2, 0);
    // reset on the edge that would end ACK, then writer 1 has priority
    add(0, 1, 4'b0001,  77,  0,  0,  0, 4'b0001, 1,   77, 0, 1);
    add(1, 1, 4'b0001,  77,  0,  0,  0, 4'b0000, 0,    0, 3, 0);
    add(0, 1, 4'b0110,   0, 21, 22,  0, 4'b0010, 1,   21, 1, 1);
    add(0, 1, 4'b0110,   0, 21, 22,  0, 4'b0000, 0,   21, 1, 0);
    add(0, 1, 4'b0100,   0, 21, 22,  0, 4'b0100, 1,   22, 2, 1);
    add(0, 0, 4'b0000,   0, 21, 22,  0, 4'b0000, 0,   22, 2, 0);

    drive(1, 0, 4'b0000, 0, 0, 0, 0);
    #2;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rd, vecs[i].req, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3);
      step();
      check($sformatf("v%0d wr_ack",   i), int'(wr_ack),   int'(vecs[i].e_ack));
      check($sformatf("v%0d rd_valid", i), int'(rd_valid), int'(vecs[i].e_valid));
      check($sformatf("v%0d rd_data",  i), int'(rd_data),  vecs[i].e_data);
      check($sformatf("v%0d grant_id", i), int'(grant_id), vecs[i].e_grant);
      check($sformatf("v%0d busy",     i), int'(busy),     int'(vecs[i].e_busy));
      check($sformatf("v%0d wr_err",   i), int'(wr_err),   0);
    end

    // reader waits with no writers: nothing happens for 20 cycles
    drive(0, 1, 4'b0000, 0, 0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("idle c%0d pulses", c), int'({rd_valid, busy, wr_ack}), 0);
    end
    drive(0, 1, 4'b1000, 0, 0, 0, -5);
    step();
    check("late rd_valid", int'(rd_valid), 1);
    check("late rd_data",  int'(rd_data),  -5);
    check("late wr_ack",   int'(wr_ack),   8);
    check("late grant_id", int'(grant_id), 3);
    drive(0, 0, 4'b0000, 0, 0, 0, -5);
    step();
    check("late pulses cleared", int'({rd_valid, busy, wr_ack}), 0);
    check("late rd_data held",   int'(rd_data), -5);

    // wait-timeout behaviour for a writer the reader never serves
    drive(1, 0, 4'b0000, 0, 0, 0, 0);
    step();
    drive(0, 0, 4'b0010, 0, 55, 0, 0);
`ifdef XBUS_TIMEOUT_EN
    n = 0;
    bad = 0;
    do begin
      step();
      n++;
      if (wr_err != 4'b0000 && wr_err != 4'b0010) bad++;
    end while (!wr_err[1] && n < 40);
    check("timeout first interval", n, 15);
    n = 0;
    do begin
      step();
      n++;
      if (wr_err != 4'b0000 && wr_err != 4'b0010) bad++;
    end while (!wr_err[1] && n < 40);
    check("timeout second interval", n, 15);
    check("timeout other writers quiet", bad, 0);
`else
    bad = 0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (wr_err != 4'b0000) bad++;
      if (rd_valid || wr_ack != 4'b0000) n++;
    end
    check("no timeout wr_err stays 0", bad, 0);
    check("no reader no transfer", n, 0);
`endif
    drive(0, 0, 4'b0000, 0, 0, 0, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
